glay_outstanding_scheduler: RTL and testbench
=============================================

// Module: glay_outstanding_scheduler
// PURPOSE
//  Round-robin scheduler that shares one memory request port between NUM_REQ engines.
//  Keeps a per-requester count of outstanding transactions and stops granting a
//  requester once it holds MAX_OUTSTANDING. Supports a drain sequence that waits for
//  all responses, then pulses done. Sits between the engine request arbiter and the
//  memory-channel request/response path.
// PARAMETERS
//  NUM_REQ          4   number of requesters (>=2)
//  CNT_WIDTH        4   width of each outstanding counter
//  MAX_OUTSTANDING  8   per-requester credit limit (1 .. 2**CNT_WIDTH-1)
//  ID_WIDTH  $clog2(NUM_REQ)   derived; width of mem_req_id / resp_id
// PORTS
//  ap_clk        in   1                  clock; all logic on posedge
//  areset        in   1                  asynchronous, active-high reset
//  start         in   1                  IDLE->RUN request
//  flush         in   1                  RUN->DRAIN request
//  req_valid     in   NUM_REQ            per-requester request pending
//  req_ready     out  NUM_REQ            per-requester request accepted this cycle
//  mem_req_valid out  1                  request presented to memory port
//  mem_req_ready in   1                  memory port accepts
//  mem_req_id    out  ID_WIDTH           index of granted requester
//  resp_valid    in   1                  one response retired
//  resp_id       in   ID_WIDTH           requester owning the response
//  outstanding   out  NUM_REQ*CNT_WIDTH  packed counters, requester 0 in LSBs
//  busy          out  1                  state != IDLE
//  done          out  1                  one-cycle pulse at end of drain
//  resp_err      out  1                  sticky: response received for a zero counter
// BEHAVIOUR
//  Reset (async): state=IDLE, all counters 0, rr_ptr 0, grant lock clear;
//   mem_req_valid=0, req_ready=0, busy=0, done=0, resp_err=0.
//  FSM: IDLE -start-> RUN; RUN -flush-> DRAIN (flush wins if raised with start);
//   DRAIN -all counters 0-> DONE; DONE -> IDLE unconditionally (done=1 in DONE only).
//   start is ignored outside IDLE. flush is ignored outside RUN.
//  Eligibility: requester i is eligible when req_valid[i]=1 and
//   outstanding[i] < MAX_OUTSTANDING.
//  Arbitration (RUN only): the eligible requester chosen is the first at or after
//   rr_ptr, searching cyclically. mem_req_valid=1 when one is chosen. mem_req_id
//   is combinational from the same cycle.
//  Grant lock: while mem_req_valid=1 and mem_req_ready=0, the chosen id is registered
//   and held until accepted, even if another requester becomes eligible. Requesters
//   must hold req_valid once asserted.
//  Transfer: occurs when mem_req_valid and mem_req_ready are both 1. On a transfer,
//   req_ready[id]=1 (combinational), counter[id]++ and rr_ptr <= id+1 (mod NUM_REQ).
//   Without a transfer, rr_ptr is unchanged.
//  Response: resp_valid decrements counter[resp_id] in any state, including IDLE.
//  Simultaneous transfer and response on the same id: counter unchanged.
//   On different ids: both updates apply.
//  A response to a zero counter leaves the counter at 0 (no wrap) and sets resp_err.
//   resp_err is cleared only by reset.
//  The counter never exceeds MAX_OUTSTANDING, because eligibility gates it.
//  DRAIN/DONE/IDLE: mem_req_valid=0. A lock pending at flush is dropped and no
//   transfer occurs. The counter update for a response arriving in the DRAIN cycle
//   that zeroes the last counter is seen next cycle; DONE follows one cycle later.
//  Latency: request-to-grant is 0 cycles (same-cycle). Counter update is visible
//   1 cycle after the event.
//  Reset mid-operation: everything returns to reset values immediately; in-flight
//   responses arriving after reset set resp_err.
// TESTING
//  T1 reset, start, req_valid=4'b1111, mem_req_ready=1 for 8 cycles, no resp
//     -> ids 0,1,2,3,0,1,2,3; each counter=2.
//  T2 req_valid[0] only, ready=1, no resp, MAX=8 -> 8 grants, then mem_req_valid=0
//     with counter[0]=8; one resp_id=0 -> exactly one further grant.
//  T3 req_valid=4'b0101, ready=0 for 3 cycles, then req 1 also raised
//     -> mem_req_id stays 0 until ready=1, then next grant goes to 1.
//  T4 counter[2]=3, same-cycle transfer id 2 and resp_id=2 -> counter[2] stays 3;
//     resp_id=3 while counter[3]=0 -> counter[3]=0, resp_err=1.
//  T5 counters {1,0,2,0}, flush, then 3 responses spaced 2 cycles apart
//     -> no grants in DRAIN; done pulses once, 2 cycles after the last response;
//     then busy=0.
//  T6 areset asserted mid-RUN with a lock pending -> outputs and counters go to 0
//     with no clock edge; start after release resumes with rr_ptr=0.

Source files
------------

// File: rtl/glay_outstanding_scheduler.sv
// Round-robin share of one memory request port across NUM_REQ engines, with
// per-requester outstanding credit limits and a flush/drain sequence that pulses done.
module glay_outstanding_scheduler #(
  parameter int NUM_REQ         = 4,
  parameter int CNT_WIDTH       = 4,
  parameter int MAX_OUTSTANDING = 8,
  parameter int ID_WIDTH        = $clog2(NUM_REQ)
) (
  input  logic                          ap_clk,
  input  logic                          areset,
  input  logic                          start,
  input  logic                          flush,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          mem_req_valid,
  input  logic                          mem_req_ready,
  output logic [ID_WIDTH-1:0]           mem_req_id,
  input  logic                          resp_valid,
  input  logic [ID_WIDTH-1:0]           resp_id,
  output logic [NUM_REQ*CNT_WIDTH-1:0]  outstanding,
  output logic                          busy,
  output logic                          done,
  output logic                          resp_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(MAX_OUTSTANDING);
  localparam logic [ID_WIDTH-1:0]  ID_LAST  = ID_WIDTH'(NUM_REQ - 1);
  localparam logic [ID_WIDTH:0]    ID_COUNT = (ID_WIDTH + 1)'(NUM_REQ);

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic [CNT_WIDTH-1:0] r_cnt [NUM_REQ];
  logic [CNT_WIDTH-1:0] w_cnt_nxt [NUM_REQ];
  logic [ID_WIDTH-1:0]  r_rr_ptr;
  logic [ID_WIDTH-1:0]  r_lock_id;
  logic                 r_lock_vld;
  logic                 r_resp_err;

  logic [NUM_REQ-1:0]   w_elig;
  logic [NUM_REQ-1:0]   w_rot;
  logic [NUM_REQ-1:0]   w_inc;
  logic [NUM_REQ-1:0]   w_dec;
  logic [NUM_REQ-1:0]   w_zero;
  logic                 w_found;
  logic [ID_WIDTH-1:0]  w_pick;
  logic [ID_WIDTH:0]    w_sum;
  logic                 w_arb_en;
  logic                 w_grant_vld;
  logic [ID_WIDTH-1:0]  w_grant_id;
  logic                 w_xfer;
  logic                 w_all_zero;
  logic                 w_err_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign w_elig[gi]  = req_valid[gi] && (r_cnt[gi] < CNT_MAX);
      assign w_zero[gi]  = (r_cnt[gi] == '0);
      assign w_inc[gi]   = w_xfer && (w_grant_id == ID_WIDTH'(gi));
      assign w_dec[gi]   = resp_valid && (resp_id == ID_WIDTH'(gi));
      assign req_ready[gi] = w_inc[gi];
      assign outstanding[gi*CNT_WIDTH +: CNT_WIDTH] = r_cnt[gi];
    end
  endgenerate

  // Rotate eligibility so bit 0 is the requester at rr_ptr; first set bit wins.
  assign w_rot = NUM_REQ'({w_elig, w_elig} >> r_rr_ptr);

  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_sum   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_sum   = {1'b0, r_rr_ptr} + (ID_WIDTH + 1)'(k);
        if (w_sum >= ID_COUNT) begin
          w_sum = w_sum - ID_COUNT;
        end
        w_pick = w_sum[ID_WIDTH-1:0];
      end
    end
  end

  // A flush cycle already suppresses the request so a locked grant never transfers.
  assign w_arb_en    = (r_state == S_RUN) && !flush;
  assign w_grant_vld = w_arb_en && (r_lock_vld || w_found);
  assign w_grant_id  = r_lock_vld ? r_lock_id : w_pick;
  assign w_xfer      = w_grant_vld && mem_req_ready;

  assign mem_req_valid = w_grant_vld;
  assign mem_req_id    = w_grant_id;

  assign w_all_zero = &w_zero;
  assign w_err_hit  = |(w_dec & ~w_inc & w_zero);

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (w_inc[i] && !w_dec[i]) begin
        w_cnt_nxt[i] = r_cnt[i] + 1'b1;
      end else if (w_dec[i] && !w_inc[i] && !w_zero[i]) begin
        w_cnt_nxt[i] = r_cnt[i] - 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start)      w_state_nxt = S_RUN;
      S_RUN:   if (flush)      w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_all_zero) w_state_nxt = S_DONE;
      default:                 w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_lock_vld <= 1'b0;
      r_lock_id  <= '0;
      r_resp_err <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      for (int i = 0; i < NUM_REQ; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
      if (w_xfer) begin
        r_rr_ptr <= (w_grant_id == ID_LAST) ? '0 : w_grant_id + 1'b1;
      end
      r_lock_vld <= w_grant_vld && !mem_req_ready;
      if (w_grant_vld) begin
        r_lock_id <= w_grant_id;
      end
      if (w_err_hit) begin
        r_resp_err <= 1'b1;
      end
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);
  assign resp_err = r_resp_err;

endmodule

// File: tb/tb_glay_outstanding_scheduler.sv
// Directed bench: per-cycle vector table with hand-computed expectations,
// plus a hand-written asynchronous reset sequence.
module tb_glay_outstanding_scheduler;

  logic        ap_clk;
  logic        areset;
  logic        start;
  logic        flush;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [1:0]  mem_req_id;
  logic        resp_valid;
  logic [1:0]  resp_id;
  logic [15:0] outstanding;
  logic        busy;
  logic        done;
  logic        resp_err;

  int n_chk  = 0;
  int n_fail = 0;

  glay_outstanding_scheduler #(
    .NUM_REQ(4), .CNT_WIDTH(4), .MAX_OUTSTANDING(8)
  ) dut (
    .ap_clk(ap_clk), .areset(areset), .start(start), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_id(mem_req_id),
    .resp_valid(resp_valid), .resp_id(resp_id), .outstanding(outstanding),
    .busy(busy), .done(done), .resp_err(resp_err)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic        rst;
    logic        start;
    logic        flush;
    logic [3:0]  req;
    logic        rdy;
    logic        rv;
    logic [1:0]  rid;
    logic        evld;
    logic [1:0]  eid;
    logic [3:0]  errdy;
    logic [15:0] eout;
    logic        ebusy;
    logic        edone;
    logic        eerr;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst, input logic st, input logic fl, input logic [3:0] req,
                     input logic rdy, input logic rv, input logic [1:0] rid,
                     input logic evld, input logic [1:0] eid, input logic [3:0] errdy,
                     input logic [15:0] eout, input logic ebusy, input logic edone,
                     input logic eerr);
    vec_t v;
    v.rst = rst; v.start = st; v.flush = fl; v.req = req; v.rdy = rdy; v.rv = rv;
    v.rid = rid; v.evld = evld; v.eid = eid; v.errdy = errdy; v.eout = eout;
    v.ebusy = ebusy; v.edone = edone; v.eerr = eerr;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic fl, input logic [3:0] req,
                       input logic rdy, input logic rv, input logic [1:0] rid);
    start = st; flush = fl; req_valid = req; mem_req_ready = rdy;
    resp_valid = rv; resp_id = rid;
  endtask

  task automatic cyc();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 4'h0, 0, 0, 2'd0);
    areset = 1'b1;
    cyc();
    cyc();
    areset = 1'b0;
  endtask

  logic [15:0] t1_out [8];

  initial begin
    areset = 1'b1;
    drive(0, 0, 4'h0, 0, 0, 2'd0);

    // T1: all four requesting, ready every cycle
    t1_out = '{16'h0000, 16'h0001, 16'h0011, 16'h0111,
               16'h1111, 16'h1112, 16'h1122, 16'h1222};
    add(1,1,0,4'h0,0,0,2'd0, 0,2'd0,4'h0,16'h0000,0,0,0);
    for (int k = 0; k < 8; k++)
      add(0,0,0,4'hF,1,0,2'd0, 1,2'(k % 4),4'(1 << (k % 4)),t1_out[k],1,0,0);
    add(0,0,0,4'h0,1,0,2'd0, 0,2'd0,4'h0,16'h2222,1,0,0);

    // T2: single requester hits the credit limit, one response frees one grant
    add(1,1,0,4'h0,0,0,2'd0, 0,2'd0,4'h0,16'h0000,0,0,0);
    for (int k = 0; k < 8; k++)
      add(0,0,0,4'h1,1,0,2'd0, 1,2'd0,4'h1,16'(k),1,0,0);
    add(0,0,0,4'h1,1,0,2'd0, 0,2'd0,4'h0,16'h0008,1,0,0);
    add(0,0,0,4'h1,1,1,2'd0, 0,2'd0,4'h0,16'h0008,1,0,0);
    add(0,0,0,4'h1,1,0,2'd0, 1,2'd0,4'h1,16'h0007,1,0,0);
    add(0,0,0,4'h1,1,0,2'd0, 0,2'd0,4'h0,16'h0008,1,0,0);
    add(0,0,0,4'h1,1,0,2'd0, 0,2'd0,4'h0,16'h0008,1,0,0);

    // T3: stalled grant to 0, requester 1 joins, next grant goes to 1
    add(1,1,0,4'h0,0,0,2'd0, 0,2'd0,4'h0,16'h0000,0,0,0);
    for (int k = 0; k < 3; k++)
      add(0,0,0,4'h5,0,0,2'd0, 1,2'd0,4'h0,16'h0000,1,0,0);
    add(0,0,0,4'h7,0,0,2'd0, 1,2'd0,4'h0,16'h0000,1,0,0);
    add(0,0,0,4'h7,1,0,2'd0, 1,2'd0,4'h1,16'h0000,1,0,0);
    add(0,0,0,4'h6,1,0,2'd0, 1,2'd1,4'h2,16'h0001,1,0,0);

    // T3b: lock on 2 holds although rr_ptr=1 would now pick newly raised 1
    add(1,1,0,4'h0,0,0,2'd0, 0,2'd0,4'h0,16'h0000,0,0,0);
    add(0,0,0,4'h1,1,0,2'd0, 1,2'd0,4'h1,16'h0000,1,0,0);
    add(0,0,0,4'h4,0,0,2'd0, 1,2'd2,4'h0,16'h0001,1,0,0);
    add(0,0,0,4'h6,0,0,2'd0, 1,2'd2,4'h0,16'h0001,1,0,0);
    add(0,0,0,4'h6,1,0,2'd0, 1,2'd2,4'h4,16'h0001,1,0,0);
    add(0,0,0,4'h2,1,0,2'd0, 1,2'd1,4'h2,16'h0101,1,0,0);
    add(0,0,0,4'h0,0,0,2'd0, 0,2'd0,4'h0,16'h0111,1,0,0);

    // T4: same-id transfer+response, different-id pair, response to zero counter
    add(1,1,0,4'h0,0,0,2'd0, 0,2'd0,4'h0,16'h0000,0,0,0);
    add(0,0,0,4'h4,1,0,2'd0, 1,2'd2,4'h4,16'h0000,1,0,0);
    add(0,0,0,4'h4,1,0,2'd0, 1,2'd2,4'h4,16'h0100,1,0,0);
    add(0,0,0,4'h4,1,0,2'd0, 1,2'd2,4'h4,16'h0200,1,0,0);
    add(0,0,0,4'h4,1,1,2'd2, 1,2'd2,4'h4,16'h0300,1,0,0);
    add(0,0,0,4'h1,1,1,2'd2, 1,2'd0,4'h1,16'h0300,1,0,0);
    add(0,0,0,4'h0,0,1,2'd3, 0,2'd0,4'h0,16'h0201,1,0,0);
    add(0,0,0,4'h0,0,0,2'd0, 0,2'd0,4'h0,16'h0201,1,0,1);
    add(0,0,0,4'h0,0,0,2'd0, 0,2'd0,4'h0,16'h0201,1,0,1);

    // T5: counters 0:1 2:2, lock pending at flush, drain with spaced responses
    add(1,1,0,4'h0,0,0,2'd0, 0,2'd0,4'h0,16'h0000,0,0,0);
    add(0,0,0,4'h1,1,0,2'd0, 1,2'd0,4'h1,16'h0000,1,0,0);
    add(0,0,0,4'h4,1,0,2'd0, 1,2'd2,4'h4,16'h0001,1,0,0);
    add(0,0,0,4'h4,1,0,2'd0, 1,2'd2,4'h4,16'h0101,1,0,0);
    add(0,0,0,4'h4,0,0,2'd0, 1,2'd2,4'h0,16'h0201,1,0,0);
    add(0,0,1,4'h4,0,0,2'd0, 0,2'd0,4'h0,16'h0201,1,0,0);
    add(0,1,0,4'hF,1,1,2'd0, 0,2'd0,4'h0,16'h0201,1,0,0);
    add(0,0,0,4'hF,1,0,2'd0, 0,2'd0,4'h0,16'h0200,1,0,0);
    add(0,0,0,4'hF,1,1,2'd2, 0,2'd0,4'h0,16'h0200,1,0,0);
    add(0,0,0,4'hF,1,0,2'd0, 0,2'd0,4'h0,16'h0100,1,0,0);
    add(0,0,0,4'hF,1,1,2'd2, 0,2'd0,4'h0,16'h0100,1,0,0);
    add(0,0,0,4'hF,1,0,2'd0, 0,2'd0,4'h0,16'h0000,1,0,0);
    add(0,0,0,4'hF,1,0,2'd0, 0,2'd0,4'h0,16'h0000,1,1,0);
    add(0,0,1,4'hF,1,0,2'd0, 0,2'd0,4'h0,16'h0000,0,0,0);
    add(0,0,0,4'h0,0,0,2'd0, 0,2'd0,4'h0,16'h0000,0,0,0);

    // Reset state, sampled before any clock edge
    #1;
    chk("rst.mem_req_valid", 32'(mem_req_valid), 0);
    chk("rst.req_ready", 32'(req_ready), 0);
    chk("rst.outstanding", 32'(outstanding), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.done", 32'(done), 0);
    chk("rst.resp_err", 32'(resp_err), 0);

    foreach (vq[i]) begin
      if (vq[i].rst) do_reset();
      drive(vq[i].start, vq[i].flush, vq[i].req, vq[i].rdy, vq[i].rv, vq[i].rid);
      #2;
      chk($sformatf("v%0d.mem_req_valid", i), 32'(mem_req_valid), 32'(vq[i].evld));
      if (vq[i].evld) chk($sformatf("v%0d.mem_req_id", i), 32'(mem_req_id), 32'(vq[i].eid));
      chk($sformatf("v%0d.req_ready", i), 32'(req_ready), 32'(vq[i].errdy));
      chk($sformatf("v%0d.outstanding", i), 32'(outstanding), 32'(vq[i].eout));
      chk($sformatf("v%0d.busy", i), 32'(busy), 32'(vq[i].ebusy));
      chk($sformatf("v%0d.done", i), 32'(done), 32'(vq[i].edone));
      chk($sformatf("v%0d.resp_err", i), 32'(resp_err), 32'(vq[i].eerr));
      cyc();
    end

    // T6: asynchronous reset mid-RUN with a lock pending on requester 1
    do_reset();
    drive(1, 0, 4'h0, 0, 0, 2'd0);
    cyc();
    drive(0, 0, 4'h1, 1, 0, 2'd0);
    #2;
    chk("t6.grant0", 32'(req_ready), 32'h1);
    cyc();
    drive(0, 0, 4'h2, 0, 0, 2'd0);
    #2;
    chk("t6.lock_vld", 32'(mem_req_valid), 1);
    chk("t6.lock_id", 32'(mem_req_id), 1);
    #1;
    areset = 1'b1;
    #1;
    chk("t6.async_mem_req_valid", 32'(mem_req_valid), 0);
    chk("t6.async_outstanding", 32'(outstanding), 0);
    chk("t6.async_busy", 32'(busy), 0);
    #2;
    areset = 1'b0;
    cyc();
    drive(1, 0, 4'hF, 0, 1, 2'd0);
    #2;
    chk("t6.idle_mem_req_valid", 32'(mem_req_valid), 0);
    chk("t6.idle_resp_err", 32'(resp_err), 0);
    cyc();
    drive(0, 0, 4'hF, 0, 0, 2'd0);
    #2;
    chk("t6.resume_vld", 32'(mem_req_valid), 1);
    chk("t6.resume_id", 32'(mem_req_id), 0);
    chk("t6.late_resp_err", 32'(resp_err), 1);
    chk("t6.resume_outstanding", 32'(outstanding), 0);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
